// File: rtl/osc_divider.sv
`default_nettype none
// ============================================================================
//  Module      : osc_divider
//  Description : Sequential restoring divider that answers the per-slot
//                start/ready divide handshake of the polyphony controller.
//                One quotient bit per cycle; the result is held until the
//                next accepted start.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;            // dividend, shifted left each step
  logic [WIDTH-1:0] dvd_orig_q, dvd_orig_d;  // dividend as latched
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // After every restoring step the remainder is below the divisor, so it
  // always fits in WIDTH bits; only the shifted value needs the extra bit.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_trial;
  logic             w_ge;
  logic             w_last;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    w_shift    = {rem_q, dvd_q[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, dvs_q});
    // True difference is below 2^WIDTH whenever it is used, so the
    // truncated subtraction is exact.
    w_trial    = w_shift[WIDTH-1:0] - dvs_q;
    w_rem_next = w_ge ? w_trial : w_shift[WIDTH-1:0];
    w_quo_next = {quo_q[WIDTH-2:0], w_ge};
    w_last     = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath control; everything holds unless told otherwise.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvd_orig_d  = dvd_orig_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d      = dividend;
          dvd_orig_d = dividend;
          dvs_d      = divisor;
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = '0;
          dz_d       = (divisor == '0);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = w_rem_next;
        quo_d = w_quo_next;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (w_last) begin
          state_d = S_DONE;
          // Published results change only here, on entry to DONE.
          // A zero divisor gets the defined answer forced.
          quotient_d  = dz_q ? '1 : w_quo_next;
          remainder_d = dz_q ? dvd_orig_q : w_rem_next;
          dbz_d       = dz_q;
        end
      end
      S_DONE: begin
        // Single result cycle; start is deliberately ignored here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvd_orig_q  <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvd_orig_q  <= dvd_orig_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ready       = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: doc/osc_divider.md
Name: osc_divider

Overview:
- Sequential restoring divider; the responder end of the start/ready divide handshake that the polyphony controller issues once per oscillator slot.
- Latches dividend/divisor on an accepted start and iterates one quotient bit per cycle.
- Pulses ready once and holds quotient/remainder stable until the next accepted start, so the controller can accumulate the result in its following cycle.

Parameters:
- WIDTH, 16, bit width of dividend, divisor, quotient and remainder (valid 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  divide request; may be held high by the controller across several cycles.
- dividend  input  WIDTH  numerator, unsigned; sampled only on the accept edge.
- divisor  input  WIDTH  denominator, unsigned; sampled only on the accept edge.
- ready  output  1  one-cycle pulse: result valid.
- busy  output  1  high while an operation is in progress (BUSY or DONE).
- quotient  output  WIDTH  unsigned quotient; held until next accept.
- remainder  output  WIDTH  unsigned remainder; held until next accept.
- div_by_zero  output  1  set with the result when the latched divisor was 0; held until next accept.

Behaviour:
- Reset (rst sampled high at a rising edge): state IDLE; ready=0, busy=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset overrides every other input, including mid-operation; no ready pulse follows an aborted operation.
- States: IDLE, BUSY, DONE.
- IDLE with start=1 at an edge (accept edge t0):
  - latch dividend and divisor; clear the working remainder (WIDTH+1 bits) and counter.
  - flag div_by_zero internally if divisor==0; go to BUSY.
- IDLE with start=0: stay; outputs hold their last values.
- BUSY, each edge (one restoring step):
  - shift the working remainder left, shifting in the current dividend MSB; shift the dividend left.
  - trial = remainder - {1'b0, divisor}.
  - if trial is non-negative: remainder = trial, shift in quotient bit 1; else shift in 0.
  - increment the counter; after WIDTH steps (edge t0+WIDTH) go to DONE.
- DONE (exactly one cycle, t0+WIDTH to t0+WIDTH+1):
  - ready=1 and busy=1.
  - quotient and remainder outputs show the final values.
  - unconditionally return to IDLE at the next edge; start is ignored in DONE.
- Divide by zero:
  - same latency; quotient = all ones, remainder = latched dividend, div_by_zero=1.
  - the iteration produces these naturally; the RTL forces them regardless.
- Output timing:
  - ready and busy are decoded from state registers, no combinational path from start.
  - quotient, remainder and div_by_zero outputs update only on entry to DONE.
  - they are stable from DONE until the DONE of the next operation, across the IDLE cycles and the whole BUSY period.
- Latency and throughput:
  - ready is high exactly WIDTH cycles after the accept edge, for one cycle.
  - with start held continuously, back-to-back accepts are WIDTH+2 edges apart (DONE cycle, then IDLE cycle, then accept).
- Operand changes during BUSY or DONE have no effect on the result in flight.
- Arithmetic: unsigned only. Invariant for divisor≠0: dividend = quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- Reset, then start pulse with dividend=100, divisor=7 (WIDTH=16) -> ready high exactly 16 cycles after the accept edge, for 1 cycle; quotient=14, remainder=2, div_by_zero=0; outputs still 14/2 three cycles later.
- dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- divisor=0, dividend=1234 -> ready at the same 16-cycle latency; quotient=16'hFFFF, remainder=1234, div_by_zero=1. A following 10/3 -> quotient=3, remainder=1, div_by_zero cleared.
- start held high continuously with operands 1000/10 then 999/4 changed at the first ready -> second accept 18 edges after the first; results 100/0 then 249/3; operand change mid-BUSY does not alter the in-flight result.
- rst asserted 5 cycles into an operation -> next cycle state IDLE, all outputs 0, no ready pulse; a new 50/6 then completes with quotient=8, remainder=2.
- Randomized sweep of 200 operand pairs -> every result satisfies the quotient/remainder invariant; busy is high for exactly WIDTH+1 cycles per operation.
